// File: rtl/pw_pkg.sv
// Shared constants and types for the password-to-MD4-block path.
// No logic; helper function is pure combinational.
// No flow control here; users handle backpressure.
package pw_pkg;

    localparam int PW_MAX_LEN   = 20;
    localparam int PW_CHAR_W    = 8;
    localparam int MD4_WORDS    = 16;
    localparam logic [7:0] MD4_PAD_BYTE = 8'h80;

    typedef logic [PW_MAX_LEN*PW_CHAR_W-1:0] pw_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Character 0 is the most significant byte of the bus.
    function automatic logic [PW_CHAR_W-1:0] char_at(input pw_t pw, input logic [4:0] idx);
        logic [PW_CHAR_W-1:0] c;
        c = '0;
        for (int j = 0; j < PW_MAX_LEN; j++) begin
            if (idx == 5'(j))
                c = pw[(PW_MAX_LEN*PW_CHAR_W-1) - PW_CHAR_W*j -: PW_CHAR_W];
        end
        return c;
    endfunction

endpackage

// File: rtl/pwblock_word.sv
// Builds one 32-bit little-endian MD4 message word of the UTF-16LE padded password.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module pwblock_word
    import pw_pkg::*;
(
    input  pw_t         password,
    input  logic [4:0]  length,
    input  logic [3:0]  index,
    output logic [31:0] word
);

    logic [5:0] byte_idx [4];
    logic [7:0] byte_val [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_idx[k] = {index, 2'(k)};
            byte_val[k] = '0;
            if (byte_idx[k] == {length, 1'b0})
                byte_val[k] = MD4_PAD_BYTE;
            else if (!byte_idx[k][0] && (byte_idx[k][5:1] < length))
                byte_val[k] = char_at(password, byte_idx[k][5:1]);
        end

        word = {byte_val[3], byte_val[2], byte_val[1], byte_val[0]};
        // Bit length of the UTF-16 message, 16 bits per character.
        if (index == 4'd14)
            word = {23'd0, length, 4'd0};
        else if (index == 4'd15)
            word = '0;
    end

endmodule

// File: rtl/pwblock.sv
// Captures a password on a trigger edge and streams its padded MD4 block as 16 words.
// Latency: word 0 valid the cycle after the start edge; one word per accepted cycle.
// Backpressure: out_ready low holds word/index/valid; build option PWBLOCK_PARALLEL_EN adds out_block.
module pwblock
    import pw_pkg::*;
#(
    parameter int MAX_LEN = PW_MAX_LEN
)(
    input  logic         clk,
    input  logic         rst_n,
    input  pw_t          in_password,
    input  logic [4:0]   in_length,
    input  logic         trigger,
    output logic [31:0]  out_word,
    output logic [3:0]   out_index,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
`ifdef PWBLOCK_PARALLEL_EN
    output logic [511:0] out_block,
`endif
    output logic         busy,
    output logic         completed,
    output logic         error
);

    state_t      state, state_nxt;
    logic        trig_q;
    logic        armed;
    logic        start;
    logic        capture;
    logic        len_bad;
    pw_t         pw_q;
    logic [4:0]  len_q;
    logic [3:0]  idx_q, idx_nxt;
    logic        completed_q, completed_nxt;
    logic        error_q, error_nxt;
    logic [31:0] gen_word;

    // A trigger held high through reset must not read as a fresh edge.
    assign start   = trigger & ~trig_q & armed;
    assign len_bad = in_length > 5'(MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        capture       = 1'b0;
        idx_nxt       = idx_q;
        completed_nxt = 1'b0;
        error_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_bad) begin
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt = EMIT;
                        capture   = 1'b1;
                        idx_nxt   = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == 4'd15) begin
                        state_nxt     = IDLE;
                        completed_nxt = 1'b1;
                        idx_nxt       = 4'd0;
                    end else begin
                        idx_nxt = idx_q + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q      <= 1'b0;
            armed       <= 1'b0;
            pw_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            completed_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            trig_q      <= trigger;
            armed       <= 1'b1;
            idx_q       <= idx_nxt;
            completed_q <= completed_nxt;
            error_q     <= error_nxt;
            if (capture) begin
                pw_q  <= in_password;
                len_q <= in_length;
            end
        end
    end

    pwblock_word u_word (
        .password (pw_q),
        .length   (len_q),
        .index    (idx_q),
        .word     (gen_word)
    );

    assign out_valid = (state == EMIT);
    assign out_word  = out_valid ? gen_word : 32'd0;
    assign out_index = idx_q;
    assign out_last  = out_valid && (idx_q == 4'd15);
    assign busy      = (state == EMIT);
    assign completed = completed_q;
    assign error     = error_q;

`ifdef PWBLOCK_PARALLEL_EN
    logic [31:0]  blk_word [MD4_WORDS];
    logic [511:0] block_q;

    // Built from the live inputs so the whole block is ready at capture.
    for (genvar w = 0; w < MD4_WORDS; w++) begin : g_blk
        pwblock_word u_blk_word (
            .password (in_password),
            .length   (in_length),
            .index    (4'(w)),
            .word     (blk_word[w])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_q <= '0;
        end else if (capture) begin
            for (int w = 0; w < MD4_WORDS; w++)
                block_q[32*w +: 32] <= blk_word[w];
        end
    end

    assign out_block = block_q;
`endif

endmodule

// File: tb/tb_pwblock.sv
// Directed bench for pwblock: vector table of passwords with expected words,
// plus error, reset and trigger-held-through-reset sequences.
module tb_pwblock;

    logic         clk;
    logic         rst_n;
    logic [159:0] in_password;
    logic [4:0]   in_length;
    logic         trigger;
    logic [31:0]  out_word;
    logic [3:0]   out_index;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         completed;
    logic         error;

    int checks = 0;
    int errors = 0;

    pwblock dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_password (in_password),
        .in_length   (in_length),
        .trigger     (trigger),
        .out_word    (out_word),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .completed   (completed),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [159:0]      pw;
        logic [4:0]        len;
        int                hold;
        bit                stall;
        bit                retrig;
        logic [15:0][31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic quiet_window(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            check("quiet_valid", 32'(out_valid), 32'd0);
            check("quiet_completed", 32'(completed), 32'd0);
        end
    endtask

    task automatic run_vec(input int v);
        int acc, cyc;
        bit done, have_hold;
        logic [31:0] held_w;
        logic [3:0]  held_i;
        acc = 0; cyc = 0; done = 0; have_hold = 0;
        held_w = '0; held_i = '0;
        @(negedge clk);
        in_password = vecs[v].pw;
        in_length   = vecs[v].len;
        out_ready   = 1'b1;
        trigger     = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            trigger   = (cyc < vecs[v].hold) || (vecs[v].retrig && cyc == 6);
            out_ready = vecs[v].stall ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
            // Inputs change after capture and must not matter.
            in_password = ~vecs[v].pw;
            in_length   = 5'd7;
            #1;
            if (cyc == 1) check("first_valid", 32'(out_valid), 32'd1);
            if (have_hold) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_word", out_word, held_w);
                check("stall_hold_index", 32'(out_index), 32'(held_i));
                have_hold = 0;
            end
            if (out_valid) begin
                if (acc >= 16) begin
                    check("extra_word", 32'(acc), 32'd15);
                    done = 1;
                end else begin
                    check("index_seq", 32'(out_index), 32'(acc));
                    check("last_flag", 32'(out_last), 32'(acc == 15));
                    check("busy_emit", 32'(busy), 32'd1);
                    check("completed_early", 32'(completed), 32'd0);
                    if (out_ready) begin
                        check($sformatf("v%0d_word%0d", v, acc), out_word, vecs[v].exp[acc]);
                        acc++;
                    end else begin
                        held_w = out_word;
                        held_i = out_index;
                        have_hold = 1;
                    end
                end
            end else if (acc == 16) begin
                check("completed_pulse", 32'(completed), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                if (!vecs[v].stall) check("completed_cycle", 32'(cyc), 32'd17);
                done = 1;
            end
        end
        if (!done) check("emission_timeout", 32'(acc), 32'd16);
        trigger   = 1'b0;
        out_ready = 1'b1;
        quiet_window(3);
    endtask

    initial begin
        rst_n = 1'b0; trigger = 1'b0; out_ready = 1'b0;
        in_password = '0; in_length = '0;

        vecs[0].pw = {20{8'h5A}};              vecs[0].len = 5'd0;
        vecs[1].pw = {8'h20, {19{8'h5A}}};     vecs[1].len = 5'd1;
        vecs[2].pw = {20{8'h41}};              vecs[2].len = 5'd20;
        vecs[3].pw = {{19{8'h41}}, 8'h42};     vecs[3].len = 5'd19;
        vecs[4].pw = {8'h61, 8'h62, 8'h63, {17{8'h5A}}}; vecs[4].len = 5'd3;
        vecs[5].pw = {8'h78, 8'h79, {18{8'h5A}}};        vecs[5].len = 5'd2;
        for (int i = 0; i < 6; i++) begin
            vecs[i].hold = 1; vecs[i].stall = 0; vecs[i].retrig = 0; vecs[i].exp = '0;
        end
        vecs[4].stall = 1;
        vecs[5].hold = 5; vecs[5].retrig = 1;

        vecs[0].exp[0] = 32'h0000_0080;
        vecs[1].exp[0] = 32'h0080_0020; vecs[1].exp[14] = 32'h0000_0010;
        for (int w = 0; w < 10; w++) vecs[2].exp[w] = 32'h0041_0041;
        vecs[2].exp[10] = 32'h0000_0080; vecs[2].exp[14] = 32'h0000_0140;
        for (int w = 0; w < 9; w++) vecs[3].exp[w] = 32'h0041_0041;
        vecs[3].exp[9] = 32'h0080_0041; vecs[3].exp[14] = 32'h0000_0130;
        vecs[4].exp[0] = 32'h0062_0061; vecs[4].exp[1] = 32'h0080_0063; vecs[4].exp[14] = 32'h0000_0030;
        vecs[5].exp[0] = 32'h0079_0078; vecs[5].exp[1] = 32'h0000_0080; vecs[5].exp[14] = 32'h0000_0020;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_completed", 32'(completed), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word", out_word, 32'd0);
        check("rst_index", 32'(out_index), 32'd0);

        // Trigger already high when reset lifts must not start
        in_length = 5'd3;
        trigger = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("held_trig_valid", 32'(out_valid), 32'd0);
            check("held_trig_busy", 32'(busy), 32'd0);
        end
        trigger = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Over-length request
        @(negedge clk);
        in_length = 5'd25; in_password = {20{8'h41}}; trigger = 1'b1;
        @(negedge clk); #1;
        check("err_pulse", 32'(error), 32'd1);
        check("err_valid", 32'(out_valid), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        trigger = 1'b0;
        @(negedge clk); #1;
        check("err_single", 32'(error), 32'd0);
        check("err_valid2", 32'(out_valid), 32'd0);
        quiet_window(2);

        // Reset in the middle of an emission
        @(negedge clk);
        in_password = vecs[4].pw; in_length = vecs[4].len; out_ready = 1'b1; trigger = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk); trigger = 1'b0; #1;
            while (!(out_valid && out_index == 4'd7) && n < 30) begin
                @(negedge clk); #1; n++;
            end
            check("mid_reached_word7", 32'(out_index), 32'd7);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_index", 32'(out_index), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet_window(12);
        run_vec(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
